player_damage_ctrl: RTL and testbench
=====================================

Name: player_damage_ctrl

Overview:
Sequences all player damage and heal events into the lives counter.
- Merges bomb-explosion and enemy collision hits into single, rate-limited hit strobes.
- Enforces a post-hit invulnerability window with sprite flicker.
- Serialises heart-pickup strobes so they never coincide with hit strobes.
- Runs the death sequence and asserts game_over.
- Sits between the collision detectors / pickup logic and the lives counter and player sprite.

Parameters:
INVULN_FRAMES, 120, frames of invulnerability after a non-fatal hit
FLICKER_FRAMES, 4, frames per visibility toggle while invulnerable
DEATH_FRAMES, 90, frames of death sequence before game_over
FRAME_CNT_W, 8, frame counter width; must hold max(INVULN_FRAMES, DEATH_FRAMES)

Ports:
clk  in  1  system clock
resetN  in  1  async reset, active-low
startOfFrame  in  1  one-clk pulse per video frame
bomb_hit  in  1  level, player overlaps explosion pixel this cycle
enemy_hit  in  1  level, player overlaps enemy pixel this cycle
heart_pickup  in  1  one-clk pulse, heart collected
player_died  in  1  from lives counter, sticky high once lives reach 0
lives_hitN  out  1  active-low one-clk strobe: decrement lives
lives_incN  out  1  active-low one-clk strobe: increment lives
player_visible  out  1  sprite enable
invulnerable  out  1  high in INVULN state
player_freeze  out  1  blocks movement/bomb placement
game_over  out  1  sticky high after death sequence
hit_src  out  2  cause of last hit: 01 bomb, 10 enemy, 00 none

Behaviour:
Reset: this block uses reset resetN, asynchronous, active-low; clock clk. All outputs are registered. Reset values:
- state=ALIVE, lives_hitN=1, lives_incN=1
- player_visible=1, invulnerable=0, player_freeze=0, game_over=0
- hit_src=00, frame_cnt=0, pend_inc=0
- Reset mid-sequence returns to these values immediately.

State machine:
- ALIVE: (bomb_hit | enemy_hit) -> HIT. hit_src latched; bomb wins if both are high in the same cycle.
- HIT: exactly 1 cycle. lives_hitN=0 in this cycle. -> CHECK.
- CHECK: 1 cycle, lets the lives counter register its update. player_died=1 -> DYING, else -> INVULN. frame_cnt cleared.
- INVULN:
  - invulnerable=1; collisions ignored.
  - frame_cnt increments on startOfFrame.
  - player_visible toggles each time frame_cnt mod FLICKER_FRAMES wraps to 0.
  - On the startOfFrame where frame_cnt reaches INVULN_FRAMES-1 -> ALIVE with player_visible=1.
- DYING:
  - player_freeze=1, player_visible=0, frame_cnt counts frames.
  - At DEATH_FRAMES-1 -> GAME_OVER.
- GAME_OVER: game_over=1, player_freeze=1, player_visible=0. Sticky until reset; all inputs ignored.

Heart pickup:
- heart_pickup sets pend_inc.
- In ALIVE or INVULN, with pend_inc=1 and lives_hitN not being driven low this cycle: lives_incN=0 for one cycle, then pend_inc clears.
- heart_pickup coincident with a hit: hit strobe first; inc strobe is issued no earlier than the cycle after CHECK.
- Second pickup while pend_inc=1 is merged (one increment).
- Pickups in DYING/GAME_OVER are discarded and pend_inc clears.
- lives_hitN and lives_incN are never low in the same cycle.

Boundaries:
- A hit held continuously produces one strobe per (INVULN_FRAMES + 2 cycles), never one per cycle.
- Collision in the same cycle as INVULN->ALIVE is not sampled; sampling resumes next cycle.
- startOfFrame in HIT/CHECK is not counted.
- frame_cnt saturates and never wraps.

Decomposition:
Shared package (game_pkg):
- state enum: ALIVE, HIT, CHECK, INVULN, DYING, GAME_OVER
- hit_src encodings: HIT_NONE, HIT_BOMB, HIT_ENEMY
- default frame constants

Sub-module: frame_timer. Loadable frame counter with startOfFrame enable, clear, terminal-count output and flicker tick. Instantiated once and shared by INVULN and DYING.

Test Plan:
- Reset, then bomb_hit=1 for 1 cycle in ALIVE -> lives_hitN low for exactly 1 cycle, hit_src=01, invulnerable=1 two cycles later.
- enemy_hit held high for 300 frames with INVULN_FRAMES=120 -> exactly 3 hit strobes, spaced 120 frames + 2 cycles apart; player_visible toggles every 4 frames inside each window.
- bomb_hit, enemy_hit and heart_pickup all high in the same cycle -> hit_src=01; lives_hitN strobe first; lives_incN strobe >=2 cycles later; never overlapping.
- player_died driven high during CHECK -> DYING: player_freeze=1, player_visible=0; game_over=1 after 90 frames; a later heart_pickup produces no lives_incN.
- Two heart_pickup pulses 3 cycles apart while lives_incN is blocked by HIT/CHECK -> a single lives_incN strobe.
- resetN asserted mid-INVULN at frame 50 -> all outputs at reset values immediately; the next hit restarts the count from 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encoding, hit-cause codes and default frame timings for the
// player damage/heal sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    ALIVE,
    HIT,
    CHECK,
    INVULN,
    DYING,
    GAME_OVER
  } state_t;

  localparam logic [1:0] HIT_NONE  = 2'b00;
  localparam logic [1:0] HIT_BOMB  = 2'b01;
  localparam logic [1:0] HIT_ENEMY = 2'b10;

  localparam int DEF_INVULN_FRAMES  = 120;
  localparam int DEF_FLICKER_FRAMES = 4;
  localparam int DEF_DEATH_FRAMES   = 90;
  localparam int DEF_FRAME_CNT_W    = 8;

  // Bomb takes priority when both collision sources fire together.
  function automatic logic [1:0] hit_cause(input logic bomb, input logic enemy);
    if (bomb) return HIT_BOMB;
    if (enemy) return HIT_ENEMY;
    return HIT_NONE;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Saturating frame counter advanced by startOfFrame, with a programmable
// terminal count and a periodic flicker tick.
module frame_timer
  import game_pkg::*;
#(
  parameter int CNT_W   = DEF_FRAME_CNT_W,
  parameter int FLICKER = DEF_FLICKER_FRAMES
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] last,
  output logic             tc,
  output logic             flick
);

  localparam logic [CNT_W-1:0] FLICK_LEN = CNT_W'(FLICKER);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  // tc fires on the frame pulse that ends the last counted frame
  assign tc      = en && (cnt == last);
  assign flick   = en && ((cnt_nxt % FLICK_LEN) == '0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/player_damage_ctrl.sv
// Turns raw collision and heart-pickup events into non-overlapping lives
// strobes, and runs the invulnerability flicker and death sequence.
module player_damage_ctrl
  import game_pkg::*;
#(
  parameter int INVULN_FRAMES  = DEF_INVULN_FRAMES,
  parameter int FLICKER_FRAMES = DEF_FLICKER_FRAMES,
  parameter int DEATH_FRAMES   = DEF_DEATH_FRAMES,
  parameter int FRAME_CNT_W    = DEF_FRAME_CNT_W
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       bomb_hit,
  input  logic       enemy_hit,
  input  logic       heart_pickup,
  input  logic       player_died,
  output logic       lives_hitN,
  output logic       lives_incN,
  output logic       player_visible,
  output logic       invulnerable,
  output logic       player_freeze,
  output logic       game_over,
  output logic [1:0] hit_src
);

  localparam logic [FRAME_CNT_W-1:0] INVULN_LAST = FRAME_CNT_W'(INVULN_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] DEATH_LAST  = FRAME_CNT_W'(DEATH_FRAMES - 1);

  state_t                 state;
  logic                   pend_inc;
  logic                   timer_en;
  logic                   timer_clear;
  logic                   timer_tc;
  logic                   timer_flick;
  logic [FRAME_CNT_W-1:0] timer_last;
  logic                   collision;
  logic                   inc_ok;

  assign timer_en    = startOfFrame && ((state == INVULN) || (state == DYING));
  assign timer_clear = (state == CHECK);
  assign timer_last  = (state == DYING) ? DEATH_LAST : INVULN_LAST;
  assign collision   = bomb_hit || enemy_hit;
  // An increment may not share a cycle with a hit strobe launched on this edge.
  assign inc_ok      = pend_inc && ((state == INVULN) || ((state == ALIVE) && !collision));

  frame_timer #(
    .CNT_W   (FRAME_CNT_W),
    .FLICKER (FLICKER_FRAMES)
  ) u_timer (
    .clk    (clk),
    .resetN (resetN),
    .en     (timer_en),
    .clear  (timer_clear),
    .last   (timer_last),
    .tc     (timer_tc),
    .flick  (timer_flick)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= ALIVE;
      lives_hitN     <= 1'b1;
      lives_incN     <= 1'b1;
      player_visible <= 1'b1;
      invulnerable   <= 1'b0;
      player_freeze  <= 1'b0;
      game_over      <= 1'b0;
      hit_src        <= HIT_NONE;
      pend_inc       <= 1'b0;
    end else begin
      lives_hitN <= 1'b1;
      lives_incN <= 1'b1;

      case (state)
        ALIVE: begin
          if (collision) begin
            state      <= HIT;
            lives_hitN <= 1'b0;
            hit_src    <= hit_cause(bomb_hit, enemy_hit);
          end
        end
        HIT: begin
          state <= CHECK;
        end
        CHECK: begin
          if (player_died) begin
            state          <= DYING;
            player_freeze  <= 1'b1;
            player_visible <= 1'b0;
          end else begin
            state        <= INVULN;
            invulnerable <= 1'b1;
          end
        end
        INVULN: begin
          if (timer_tc) begin
            state          <= ALIVE;
            invulnerable   <= 1'b0;
            player_visible <= 1'b1;
          end else if (timer_flick) begin
            player_visible <= !player_visible;
          end
        end
        DYING: begin
          if (timer_tc) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
          end
        end
        GAME_OVER: begin
          state <= GAME_OVER;
        end
        default: begin
          state <= ALIVE;
        end
      endcase

      // Pickups are single-slot: a repeat while one is pending is merged.
      if ((state == DYING) || (state == GAME_OVER)) begin
        pend_inc <= 1'b0;
      end else if (inc_ok) begin
        lives_incN <= 1'b0;
        pend_inc   <= 1'b0;
      end else if (heart_pickup) begin
        pend_inc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_player_damage_ctrl.sv
// Scoreboard bench for player_damage_ctrl: tasks queue the strobes they expect
// and a monitor matches them against the DUT strobes and invulnerable windows.
`timescale 1ns/1ps
module tb_player_damage_ctrl;
  import game_pkg::*;

  localparam int INV   = 120;
  localparam int FLK   = 4;
  localparam int DTH   = 90;
  localparam int FRAME = 8;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       bomb_hit = 1'b0;
  logic       enemy_hit = 1'b0;
  logic       heart_pickup = 1'b0;
  logic       player_died = 1'b0;
  logic       lives_hitN;
  logic       lives_incN;
  logic       player_visible;
  logic       invulnerable;
  logic       player_freeze;
  logic       game_over;
  logic [1:0] hit_src;

  typedef struct {
    bit         is_inc;
    logic [1:0] src;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   win_done = 0;
  int   inc_seen = 0;
  int   last_hit_cyc = 0;
  int   last_inc_cyc = 0;

  player_damage_ctrl #(
    .INVULN_FRAMES  (INV),
    .FLICKER_FRAMES (FLK),
    .DEATH_FRAMES   (DTH),
    .FRAME_CNT_W    (8)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .bomb_hit       (bomb_hit),
    .enemy_hit      (enemy_hit),
    .heart_pickup   (heart_pickup),
    .player_died    (player_died),
    .lives_hitN     (lives_hitN),
    .lives_incN     (lives_incN),
    .player_visible (player_visible),
    .invulnerable   (invulnerable),
    .player_freeze  (player_freeze),
    .game_over      (game_over),
    .hit_src        (hit_src)
  );

  always #5 clk = ~clk;

  // Free-running frame pulse, one clock wide every FRAME cycles.
  initial begin
    int fcnt;
    fcnt = 0;
    forever begin
      @(negedge clk);
      fcnt = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
      startOfFrame = (fcnt == 0);
    end
  end

  // Strobe scoreboard plus invulnerable-window and flicker cadence tracking.
  initial begin
    exp_t e;
    logic inv_prev;
    logic vis_prev;
    int   win_sof;
    int   flick_sof;
    inv_prev = 1'b0;
    vis_prev = 1'b1;
    win_sof = 0;
    flick_sof = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!resetN) begin
        inv_prev = 1'b0;
        vis_prev = 1'b1;
        win_sof = 0;
        flick_sof = 0;
      end else begin
        if (!lives_hitN || !lives_incN) begin
          checks++;
          if (!lives_incN) begin inc_seen++; last_inc_cyc = cyc; end
          if (!lives_hitN) last_hit_cyc = cyc;
          if (!lives_hitN && !lives_incN) begin
            errors++;
            $display("FAIL strobe_overlap: hitN=%b incN=%b, required never both low", lives_hitN, lives_incN);
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: hitN=%b incN=%b at cycle %0d, required no strobe", lives_hitN, lives_incN, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.is_inc && lives_incN !== 1'b0) begin
              errors++;
              $display("FAIL strobe_kind: got hit strobe, required inc strobe");
            end else if (!e.is_inc && (lives_hitN !== 1'b0 || hit_src !== e.src)) begin
              errors++;
              $display("FAIL hit_strobe: hitN=%b hit_src=%b, required hitN=0 hit_src=%b", lives_hitN, hit_src, e.src);
            end
          end
        end
        if (inv_prev && startOfFrame) begin
          win_sof++;
          flick_sof++;
        end
        if (!inv_prev && invulnerable) begin
          win_sof = 0;
          flick_sof = 0;
        end
        if (inv_prev && invulnerable && (player_visible !== vis_prev)) begin
          checks++;
          if (flick_sof != FLK) begin
            errors++;
            $display("FAIL flicker_period: toggled after %0d frames, required %0d", flick_sof, FLK);
          end
          flick_sof = 0;
        end
        if (inv_prev && !invulnerable) begin
          checks++;
          if (win_sof != INV) begin
            errors++;
            $display("FAIL invuln_window: %0d frames, required %0d", win_sof, INV);
          end
          if (player_visible !== 1'b1) begin
            errors++;
            $display("FAIL invuln_exit_visible: %b, required 1", player_visible);
          end
          win_done++;
        end
        inv_prev = invulnerable;
        vis_prev = player_visible;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    resetN = 1'b0;
    bomb_hit = 1'b0;
    enemy_hit = 1'b0;
    heart_pickup = 1'b0;
    player_died = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++;
    if ({lives_hitN, lives_incN, player_visible, invulnerable, player_freeze, game_over, hit_src} !== 8'b1110_0000) begin
      errors++;
      $display("FAIL reset_values: %b, required 11100000",
               {lives_hitN, lives_incN, player_visible, invulnerable, player_freeze, game_over, hit_src});
    end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({lives_hitN, lives_incN, player_visible, invulnerable, player_freeze, game_over, hit_src} !== 8'b1110_0000) begin
      errors++;
      $display("FAIL idle_after_reset: %b, required 11100000",
               {lives_hitN, lives_incN, player_visible, invulnerable, player_freeze, game_over, hit_src});
    end
  endtask

  task automatic test_bomb_single();
    apply_reset();
    exp_q.push_back('{is_inc: 1'b0, src: HIT_BOMB});
    bomb_hit = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (lives_hitN !== 1'b0 || hit_src !== HIT_BOMB) begin
      errors++;
      $display("FAIL bomb_strobe: hitN=%b hit_src=%b, required 0 01", lives_hitN, hit_src);
    end
    @(negedge clk);
    bomb_hit = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (lives_hitN !== 1'b1 || invulnerable !== 1'b0) begin
      errors++;
      $display("FAIL bomb_check_cycle: hitN=%b inv=%b, required 1 0", lives_hitN, invulnerable);
    end
    @(posedge clk); #1;
    checks++;
    if (invulnerable !== 1'b1 || player_freeze !== 1'b0) begin
      errors++;
      $display("FAIL bomb_invuln: inv=%b freeze=%b, required 1 0", invulnerable, player_freeze);
    end
    @(negedge clk);
    bomb_hit = 1'b1;
    @(negedge clk);
    bomb_hit = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || hit_src !== HIT_BOMB) begin
      errors++;
      $display("FAIL bomb_pending: queue=%0d hit_src=%b, required 0 01", exp_q.size(), hit_src);
    end
  endtask

  task automatic test_heart_alive();
    apply_reset();
    exp_q.push_back('{is_inc: 1'b1, src: HIT_NONE});
    heart_pickup = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (lives_incN !== 1'b1) begin
      errors++;
      $display("FAIL heart_latency0: incN=%b, required 1", lives_incN);
    end
    @(negedge clk);
    heart_pickup = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (lives_incN !== 1'b0) begin
      errors++;
      $display("FAIL heart_strobe: incN=%b, required 0", lives_incN);
    end
    @(posedge clk); #1;
    checks++;
    if (lives_incN !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL heart_single: incN=%b queue=%0d, required 1 0", lives_incN, exp_q.size());
    end
  endtask

  task automatic test_held_enemy();
    int base;
    apply_reset();
    base = win_done;
    repeat (3) exp_q.push_back('{is_inc: 1'b0, src: HIT_ENEMY});
    enemy_hit = 1'b1;
    repeat (300 * FRAME) @(negedge clk);
    enemy_hit = 1'b0;
    for (int i = 0; i < 200 * FRAME && invulnerable; i++) @(negedge clk);
    checks++;
    if (invulnerable !== 1'b0) begin
      errors++;
      $display("FAIL held_timeout: invulnerable=%b, required 0 within budget", invulnerable);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || (win_done - base) != 3) begin
      errors++;
      $display("FAIL held_hit_count: pending=%0d windows=%0d, required 0 3", exp_q.size(), win_done - base);
    end
  endtask

  task automatic test_all_coincident();
    int start;
    apply_reset();
    start = inc_seen;
    exp_q.push_back('{is_inc: 1'b0, src: HIT_BOMB});
    exp_q.push_back('{is_inc: 1'b1, src: HIT_NONE});
    bomb_hit = 1'b1;
    enemy_hit = 1'b1;
    heart_pickup = 1'b1;
    @(negedge clk);
    bomb_hit = 1'b0;
    enemy_hit = 1'b0;
    heart_pickup = 1'b0;
    for (int i = 0; i < 20 && inc_seen == start; i++) @(negedge clk);
    checks++;
    if (inc_seen != start + 1) begin
      errors++;
      $display("FAIL coinc_inc_seen: %0d incs, required 1", inc_seen - start);
    end
    checks++;
    if ((last_inc_cyc - last_hit_cyc) < 2 || hit_src !== HIT_BOMB) begin
      errors++;
      $display("FAIL coinc_order: inc-hit gap=%0d hit_src=%b, required >=2 01", last_inc_cyc - last_hit_cyc, hit_src);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL coinc_pending: %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_death();
    int   n;
    int   lows;
    logic sof;
    apply_reset();
    exp_q.push_back('{is_inc: 1'b0, src: HIT_ENEMY});
    enemy_hit = 1'b1;
    @(negedge clk);
    enemy_hit = 1'b0;
    @(negedge clk);
    player_died = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (player_freeze !== 1'b1 || player_visible !== 1'b0 || invulnerable !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL dying_outputs: frz=%b vis=%b inv=%b go=%b, required 1 0 0 0",
               player_freeze, player_visible, invulnerable, game_over);
    end
    n = 0;
    for (int i = 0; i < (DTH + 5) * FRAME && !game_over; i++) begin
      @(posedge clk);
      sof = startOfFrame;
      #1;
      if (sof) n++;
    end
    checks++;
    if (game_over !== 1'b1 || n != DTH) begin
      errors++;
      $display("FAIL death_length: game_over=%b after %0d frames, required 1 after %0d", game_over, n, DTH);
    end
    @(negedge clk);
    heart_pickup = 1'b1;
    @(negedge clk);
    heart_pickup = 1'b0;
    enemy_hit = 1'b1;
    @(negedge clk);
    enemy_hit = 1'b0;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!lives_incN || !lives_hitN) lows++;
    end
    checks++;
    if (lows != 0 || game_over !== 1'b1 || player_freeze !== 1'b1 || player_visible !== 1'b0) begin
      errors++;
      $display("FAIL game_over_sticky: strobes=%0d go=%b frz=%b vis=%b, required 0 1 1 0",
               lows, game_over, player_freeze, player_visible);
    end
  endtask

  task automatic test_merge_pickups();
    int start;
    apply_reset();
    start = inc_seen;
    exp_q.push_back('{is_inc: 1'b0, src: HIT_ENEMY});
    exp_q.push_back('{is_inc: 1'b1, src: HIT_NONE});
    heart_pickup = 1'b1;
    @(negedge clk);
    heart_pickup = 1'b0;
    enemy_hit = 1'b1;
    @(negedge clk);
    enemy_hit = 1'b0;
    @(negedge clk);
    heart_pickup = 1'b1;
    @(negedge clk);
    heart_pickup = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (inc_seen - start != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL merge_pickups: incs=%0d pending=%0d, required 1 0", inc_seen - start, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_invuln();
    int   n;
    int   base;
    logic sof;
    apply_reset();
    exp_q.push_back('{is_inc: 1'b0, src: HIT_ENEMY});
    enemy_hit = 1'b1;
    @(negedge clk);
    enemy_hit = 1'b0;
    for (int i = 0; i < 10 && !invulnerable; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 60 * FRAME && n < 50; i++) begin
      @(posedge clk);
      sof = startOfFrame;
      #1;
      if (sof && invulnerable) n++;
    end
    checks++;
    if (n != 50 || invulnerable !== 1'b1) begin
      errors++;
      $display("FAIL mid_invuln_reach: frames=%0d inv=%b, required 50 1", n, invulnerable);
    end
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++;
    if ({lives_hitN, lives_incN, player_visible, invulnerable, player_freeze, game_over, hit_src} !== 8'b1110_0000) begin
      errors++;
      $display("FAIL mid_reset_values: %b, required 11100000",
               {lives_hitN, lives_incN, player_visible, invulnerable, player_freeze, game_over, hit_src});
    end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    base = win_done;
    exp_q.push_back('{is_inc: 1'b0, src: HIT_ENEMY});
    enemy_hit = 1'b1;
    @(negedge clk);
    enemy_hit = 1'b0;
    for (int i = 0; i < (INV + 10) * FRAME && win_done == base; i++) @(negedge clk);
    checks++;
    if (win_done != base + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_window: windows=%0d pending=%0d, required 1 0", win_done - base, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_bomb_single();
    test_heart_alive();
    test_held_enemy();
    test_all_coincident();
    test_death();
    test_merge_pickups();
    test_reset_mid_invuln();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
